// File: rtl/apb_tlc_master.sv
// APB requester that steps the traffic-light slave (CTRL write, then STATUS readback).
// Define TLC_MASTER_CHECK_EN to compare each readback against the expected lamp sequence.
module apb_tlc_master #(
    parameter int unsigned DWELL_CYCLES   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 8,
    parameter logic [31:0] CTRL_ADDR      = 32'h0000_0004,
    parameter logic [31:0] STATUS_ADDR    = 32'h0000_0000
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        en,
    input  logic        step_req,
    input  logic        err_clr,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    input  logic        pready,
    input  logic        pslverr,
    input  logic [31:0] prdata,
    output logic [2:0]  lamp_a,
    output logic [2:0]  lamp_b,
    output logic        status_valid,
    output logic [15:0] step_count,
    output logic        busy,
    output logic        err,
    output logic        mismatch
);

    localparam int DW = $clog2(DWELL_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST   = DW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, W_SETUP, W_ACCESS, GAP, R_SETUP, R_ACCESS
    } state_t;

    state_t         state_q, state_d;
    logic [DW-1:0]  timer_q, timer_d;
    logic [TW-1:0]  acc_q, acc_d;
    logic           pend_q, pend_d;
    logic [15:0]    step_count_q, step_count_d;
    logic           err_q, err_d;
    logic [2:0]     lamp_a_q, lamp_a_d, lamp_b_q, lamp_b_d;
    logic           status_valid_q, status_valid_d;
    logic           psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [31:0]    paddr_q, paddr_d, pwdata_q, pwdata_d;
    logic           busy_q, busy_d;

    logic start, acc_phase, timeout, wr_ok, rd_ok, xfer_err;

    // Only the lamp fields of STATUS are consumed.
    logic unused_prdata;
    assign unused_prdata = ^{prdata[31:19], prdata[15:3]};

    always_comb begin
        start     = (state_q == IDLE) && (pend_q || (en && (timer_q == DWELL_LAST)));
        acc_phase = (state_q == W_ACCESS) || (state_q == R_ACCESS);
        timeout   = acc_phase && !pready && (acc_q == TIMEOUT_LAST);
        wr_ok     = (state_q == W_ACCESS) && pready && !pslverr;
        rd_ok     = (state_q == R_ACCESS) && pready && !pslverr;
        xfer_err  = acc_phase && pready && pslverr;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = W_SETUP;
            W_SETUP:  state_d = W_ACCESS;
            W_ACCESS: begin
                if (pready)       state_d = pslverr ? IDLE : GAP;
                else if (timeout) state_d = IDLE;
            end
            GAP:      state_d = R_SETUP;
            R_SETUP:  state_d = R_ACCESS;
            R_ACCESS: if (pready || timeout) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they line up with state_q.
    always_comb begin
        timer_d        = timer_q;
        acc_d          = acc_q;
        pend_d         = step_req | (pend_q & ~start);
        step_count_d   = step_count_q + 16'(wr_ok);
        err_d          = (xfer_err || timeout) ? 1'b1 : (err_clr ? 1'b0 : err_q);
        lamp_a_d       = lamp_a_q;
        lamp_b_d       = lamp_b_q;
        status_valid_d = rd_ok;
        paddr_d        = paddr_q;
        pwdata_d       = pwdata_q;

        if (!en || start)          timer_d = '0;
        else if (state_q == IDLE)  timer_d = timer_q + DW'(1);

        if ((state_q == W_SETUP) || (state_q == R_SETUP)) acc_d = '0;
        else if (acc_phase)                               acc_d = acc_q + TW'(1);

        if (rd_ok) begin
            lamp_a_d = prdata[2:0];
            lamp_b_d = prdata[18:16];
        end

        psel_d    = (state_d == W_SETUP) || (state_d == W_ACCESS) ||
                    (state_d == R_SETUP) || (state_d == R_ACCESS);
        penable_d = (state_d == W_ACCESS) || (state_d == R_ACCESS);
        pwrite_d  = (state_d == W_SETUP) || (state_d == W_ACCESS);
        busy_d    = (state_d != IDLE);
        if (pwrite_d) begin
            paddr_d  = CTRL_ADDR;
            pwdata_d = 32'd1;
        end else if (psel_d) begin
            paddr_d  = STATUS_ADDR;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            timer_q        <= '0;
            acc_q          <= '0;
            pend_q         <= 1'b0;
            step_count_q   <= 16'd0;
            err_q          <= 1'b0;
            lamp_a_q       <= 3'b100;
            lamp_b_q       <= 3'b001;
            status_valid_q <= 1'b0;
            psel_q         <= 1'b0;
            penable_q      <= 1'b0;
            pwrite_q       <= 1'b0;
            paddr_q        <= 32'd0;
            pwdata_q       <= 32'd0;
            busy_q         <= 1'b0;
        end else begin
            timer_q        <= timer_d;
            acc_q          <= acc_d;
            pend_q         <= pend_d;
            step_count_q   <= step_count_d;
            err_q          <= err_d;
            lamp_a_q       <= lamp_a_d;
            lamp_b_q       <= lamp_b_d;
            status_valid_q <= status_valid_d;
            psel_q         <= psel_d;
            penable_q      <= penable_d;
            pwrite_q       <= pwrite_d;
            paddr_q        <= paddr_d;
            pwdata_q       <= pwdata_d;
            busy_q         <= busy_d;
        end
    end

`ifdef TLC_MASTER_CHECK_EN
    logic [2:0] idx_q, idx_d;
    logic       mismatch_q, mismatch_d;
    logic [5:0] exp_status;

    // Expected {lamp_b, lamp_a} after the write that moved the index.
    always_comb begin
        case (idx_q)
            3'd0:    exp_status = {3'b001, 3'b100};
            3'd1:    exp_status = {3'b001, 3'b010};
            3'd2:    exp_status = {3'b001, 3'b001};
            3'd3:    exp_status = {3'b100, 3'b001};
            3'd4:    exp_status = {3'b010, 3'b001};
            default: exp_status = {3'b001, 3'b001};
        endcase
        idx_d = wr_ok ? ((idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1) : idx_q;
        if (rd_ok && ({prdata[18:16], prdata[2:0]} != exp_status)) mismatch_d = 1'b1;
        else if (err_clr)                                         mismatch_d = 1'b0;
        else                                                      mismatch_d = mismatch_q;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            idx_q      <= 3'd0;
            mismatch_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

    assign paddr        = paddr_q;
    assign pwdata       = pwdata_q;
    assign psel         = psel_q;
    assign penable      = penable_q;
    assign pwrite       = pwrite_q;
    assign lamp_a       = lamp_a_q;
    assign lamp_b       = lamp_b_q;
    assign status_valid = status_valid_q;
    assign step_count   = step_count_q;
    assign busy         = busy_q;
    assign err          = err_q;

endmodule

// File: tb/tb_apb_tlc_master.sv
// Self-checking bench for apb_tlc_master with a behavioural traffic-light APB slave.
module tb_apb_tlc_master;

    localparam int DWELL = 16;
    localparam int TMO   = 8;
`ifdef TLC_MASTER_CHECK_EN
    localparam logic MM_EXP = 1'b1;
`else
    localparam logic MM_EXP = 1'b0;
`endif

    logic        pclk = 1'b0;
    logic        preset, en, step_req, err_clr;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [2:0]  lamp_a, lamp_b;
    logic        status_valid, busy, err, mismatch;
    logic [15:0] step_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 pclk = ~pclk;

    apb_tlc_master #(
        .DWELL_CYCLES(DWELL), .TIMEOUT_CYCLES(TMO),
        .CTRL_ADDR(32'h0000_0004), .STATUS_ADDR(32'h0000_0000)
    ) dut (
        .pclk(pclk), .preset(preset), .en(en), .step_req(step_req), .err_clr(err_clr),
        .paddr(paddr), .pwdata(pwdata), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pready(pready), .pslverr(pslverr), .prdata(prdata),
        .lamp_a(lamp_a), .lamp_b(lamp_b), .status_valid(status_valid),
        .step_count(step_count), .busy(busy), .err(err), .mismatch(mismatch)
    );

    // Slave model: pready in the 2nd access cycle unless stalled.
    logic [2:0] slv_state;
    int         slv_acc;
    logic       stall, wr_err_inj, rd_err_inj, corrupt;

    function automatic logic [31:0] slvWord(input logic [2:0] s);
        case (s)
            3'd0:    return 32'h0001_0004;
            3'd1:    return 32'h0001_0002;
            3'd2:    return 32'h0001_0001;
            3'd3:    return 32'h0004_0001;
            3'd4:    return 32'h0002_0001;
            default: return 32'h0001_0001;
        endcase
    endfunction

    assign pready  = psel && penable && !stall && (slv_acc >= 1);
    assign pslverr = pready && (pwrite ? wr_err_inj : rd_err_inj);
    assign prdata  = corrupt ? 32'h0001_0001 : slvWord(slv_state);

    always @(posedge pclk or posedge preset) begin
        if (preset) begin
            slv_state <= 3'd0;
            slv_acc   <= 0;
        end else if (psel && penable) begin
            if (pready) begin
                slv_acc <= 0;
                if (pwrite && !pslverr && paddr == 32'h4 && pwdata[0])
                    slv_state <= (slv_state == 3'd5) ? 3'd0 : slv_state + 3'd1;
            end else begin
                slv_acc <= slv_acc + 1;
            end
        end else begin
            slv_acc <= 0;
        end
    end

    typedef struct {
        logic        wr_err;
        logic        rd_err;
        logic        corrupt;
        logic        exp_valid;
        logic [2:0]  exp_a;
        logic [2:0]  exp_b;
        logic [15:0] exp_cnt;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Pulse step_req and follow one sequence until busy drops again.
    task automatic applyStimulus(input vec_t v, output logic saw_valid, output logic done);
        logic seen_busy;
        wr_err_inj = v.wr_err;
        rd_err_inj = v.rd_err;
        corrupt    = v.corrupt;
        step_req   = 1'b1;
        @(negedge pclk);
        step_req   = 1'b0;
        saw_valid  = 1'b0;
        done       = 1'b0;
        seen_busy  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            if (status_valid) saw_valid = 1'b1;
            if (busy) seen_busy = 1'b1;
            else if (seen_busy) begin
                done = 1'b1;
                break;
            end
        end
        wr_err_inj = 1'b0;
        rd_err_inj = 1'b0;
        corrupt    = 1'b0;
    endtask

    initial begin
        int   cnt, k, nvalid, acc;
        logic sv, dn, found;
        vec_t cv;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 3'b001, 16'd1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 3'b001, 16'd2, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 3'b001, 16'd2, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 3'b100, 16'd3, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 3'b100, 16'd4, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 3'b001, 16'd5, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 3'b001, 16'd6, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 3'b001, 16'd7, 1'b0};

        preset = 1'b1; en = 1'b0; step_req = 1'b0; err_clr = 1'b0;
        stall = 1'b0; wr_err_inj = 1'b0; rd_err_inj = 1'b0; corrupt = 1'b0;
        repeat (2) @(negedge pclk);
        checkOutput("rst_psel", psel, 0);
        checkOutput("rst_penable", penable, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_paddr", paddr, 0);
        checkOutput("rst_lamp_a", lamp_a, 3'b100);
        checkOutput("rst_lamp_b", lamp_b, 3'b001);
        checkOutput("rst_step_count", step_count, 0);

        // Automatic stepping: first write after DWELL edges, then DWELL+7 period.
        preset = 1'b0;
        en     = 1'b1;
        cnt    = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            cnt++;
            if (psel) break;
        end
        checkOutput("first_wsetup_cycle", cnt, DWELL);
        checkOutput("wsetup_paddr", paddr, 32'h4);
        checkOutput("wsetup_pwdata", pwdata, 32'h1);
        checkOutput("wsetup_pwrite", pwrite, 1);
        checkOutput("wsetup_penable", penable, 0);
        checkOutput("wsetup_busy", busy, 1);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            k++;
            if (k == 1) checkOutput("waccess_penable", penable, 1);
            if (k == 3) checkOutput("gap_psel", psel, 0);
            if (k == 3) checkOutput("gap_busy", busy, 1);
            if (k == 4) checkOutput("rsetup_pwrite", pwrite, 0);
            if (status_valid) break;
        end
        checkOutput("status_valid_offset", k, 7);
        checkOutput("step1_lamp_a", lamp_a, 3'b010);
        checkOutput("step1_lamp_b", lamp_b, 3'b001);
        checkOutput("step1_count", step_count, 1);
        @(negedge pclk);
        k++;
        checkOutput("status_valid_pulse_end", status_valid, 0);
        for (int i = 0; i < 40; i++) begin
            if (psel) break;
            @(negedge pclk);
            k++;
        end
        checkOutput("auto_period", k, DWELL + 7);
        nvalid = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge pclk);
            if (status_valid) nvalid++;
            if (nvalid == 6) break;
        end
        checkOutput("auto6_valids", nvalid, 6);
        checkOutput("auto6_lamp_a", lamp_a, 3'b100);
        checkOutput("auto6_lamp_b", lamp_b, 3'b001);
        checkOutput("auto6_count", step_count, 6);
        checkOutput("auto6_mismatch", mismatch, 0);
        en = 1'b0;
        repeat (30) @(negedge pclk);
        checkOutput("en_off_count", step_count, 6);
        checkOutput("en_off_busy", busy, 0);

        // Table of manual steps with injected slave errors.
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], sv, dn);
            checkOutput($sformatf("vec%0d_done", i), dn, 1);
            checkOutput($sformatf("vec%0d_valid", i), sv, vecs[i].exp_valid);
            checkOutput($sformatf("vec%0d_lamp_a", i), lamp_a, vecs[i].exp_a);
            checkOutput($sformatf("vec%0d_lamp_b", i), lamp_b, vecs[i].exp_b);
            checkOutput($sformatf("vec%0d_count", i), step_count, vecs[i].exp_cnt);
            checkOutput($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            checkOutput($sformatf("vec%0d_mismatch", i), mismatch, 0);
            err_clr = 1'b1;
            @(negedge pclk);
            err_clr = 1'b0;
        end

        // Three step_req pulses around one sequence collapse into two sequences.
        step_req = 1'b1;
        @(negedge pclk);
        step_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            if (busy) begin found = 1'b1; break; end
        end
        checkOutput("collapse_started", found, 1);
        step_req = 1'b1; @(negedge pclk); step_req = 1'b0; @(negedge pclk);
        step_req = 1'b1; @(negedge pclk); step_req = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            if (status_valid) nvalid++;
        end
        checkOutput("collapse_sequences", nvalid, 2);
        checkOutput("collapse_count", step_count, 9);

        // Timeout on a stalled write, then err_clr.
        for (int pass = 0; pass < 2; pass++) begin
            stall    = 1'b1;
            err_clr  = (pass == 1);
            step_req = 1'b1;
            @(negedge pclk);
            step_req = 1'b0;
            acc = 0;
            found = 1'b0;
            dn = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge pclk);
                if (psel && penable) acc++;
                if (busy) found = 1'b1;
                else if (found) begin dn = 1'b1; break; end
            end
            checkOutput($sformatf("tmo%0d_done", pass), dn, 1);
            checkOutput($sformatf("tmo%0d_access_cycles", pass), acc, TMO);
            checkOutput($sformatf("tmo%0d_psel", pass), psel, 0);
            checkOutput($sformatf("tmo%0d_err", pass), err, 1);
            checkOutput($sformatf("tmo%0d_count", pass), step_count, 9);
            checkOutput($sformatf("tmo%0d_lamp_b", pass), lamp_b, 3'b100);
            stall   = 1'b0;
            err_clr = 1'b1;
            @(negedge pclk);
            err_clr = 1'b0;
            checkOutput($sformatf("tmo%0d_err_clr", pass), err, 0);
        end

        // Corrupted readback when Y/R is expected.
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        cv = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b001, 3'b001, 16'd1, 1'b0};
        applyStimulus(cv, sv, dn);
        checkOutput("corrupt_valid", sv, 1);
        checkOutput("corrupt_lamp_a", lamp_a, 3'b001);
        checkOutput("corrupt_lamp_b", lamp_b, 3'b001);
        checkOutput("corrupt_mismatch", mismatch, MM_EXP);
        err_clr = 1'b1;
        @(negedge pclk);
        err_clr = 1'b0;
        checkOutput("mismatch_clr", mismatch, 0);

        // Asynchronous reset in the middle of the write access phase.
        step_req = 1'b1;
        @(negedge pclk);
        step_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            if (penable && pwrite) begin found = 1'b1; break; end
        end
        checkOutput("midreset_reached_waccess", found, 1);
        preset = 1'b1;
        #1;
        checkOutput("midreset_psel", psel, 0);
        checkOutput("midreset_penable", penable, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_lamp_a", lamp_a, 3'b100);
        checkOutput("midreset_lamp_b", lamp_b, 3'b001);
        checkOutput("midreset_count", step_count, 0);
        @(negedge pclk);
        preset = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
